// File: rtl/activation_pkg.sv
`default_nettype none
// ============================================================================
// Module   : activation_pkg
// Brief    : Shared types for the run-time selectable activation unit.
// Revision : 1.0 - initial release
// ============================================================================
package activation_pkg;

  // Activation function selector; RSVD is treated like STEP.
  typedef enum logic [1:0] {
    STEP = 2'd0,
    RELU = 2'd1,
    HSIG = 2'd2,
    RSVD = 2'd3
  } mode_t;

  // Transaction phase: argument in, activation out, feedback in, delta out.
  typedef enum logic [1:0] {
    ARG = 2'd0,
    ACT = 2'd1,
    FBK = 2'd2,
    DEL = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/activation_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : activation_unit_if
// Brief    : Bundles the four valid/ready streams of the activation unit.
//            master = environment side, slave = activation unit side.
// Revision : 1.0 - initial release
// ============================================================================
interface activation_unit_if #(
  parameter int ARG_WIDTH = 16,
  parameter int ACT_WIDTH = 8,
  parameter int FBK_WIDTH = 16
);

  logic                        argument_valid;
  logic signed [ARG_WIDTH-1:0] argument_data;
  logic                        argument_ready;

  logic                        activation_valid;
  logic        [ACT_WIDTH-1:0] activation_data;
  logic                        activation_ready;

  logic                        feedback_valid;
  logic        [FBK_WIDTH-1:0] feedback_data;
  logic                        feedback_ready;

  logic                        delta_valid;
  logic        [FBK_WIDTH-1:0] delta_data;
  logic                        delta_ready;

  modport master (
    output argument_valid, argument_data, activation_ready,
           feedback_valid, feedback_data, delta_ready,
    input  argument_ready, activation_valid, activation_data,
           feedback_ready, delta_valid, delta_data
  );

  modport slave (
    input  argument_valid, argument_data, activation_ready,
           feedback_valid, feedback_data, delta_ready,
    output argument_ready, activation_valid, activation_data,
           feedback_ready, delta_valid, delta_data
  );

endinterface
`default_nettype wire

// File: rtl/activation_function.sv
`default_nettype none
// ============================================================================
// Module   : activation_function
// Brief    : Combinational step / saturating-ReLU / hard-sigmoid evaluation
//            plus the derivative-region flag used to mask gradients.
// Revision : 1.0 - initial release
// ============================================================================
module activation_function
  import activation_pkg::*;
#(
  parameter int ARG_WIDTH = 16,
  parameter int ACT_WIDTH = 8,
  parameter int SHIFT     = 4
) (
  input  mode_t                       mode,
  input  logic signed [ARG_WIDTH-1:0] argument,
  output logic        [ACT_WIDTH-1:0] act,
  output logic                        pass
);

  // Constants held one bit wider than the argument so the hard-sigmoid
  // offset can never overflow.
  localparam logic signed [ARG_WIDTH:0] C_ACT_MAX =
    $signed({{(ARG_WIDTH+1-ACT_WIDTH){1'b0}}, {ACT_WIDTH{1'b1}}});
  localparam logic signed [ARG_WIDTH:0] C_HALF =
    $signed({{(ARG_WIDTH+1-ACT_WIDTH){1'b0}}, 1'b1, {(ACT_WIDTH-1){1'b0}}});

  logic                      w_negative;
  logic signed [ARG_WIDTH:0] w_scaled;
  logic signed [ARG_WIDTH:0] w_hsig;

  assign w_negative = argument[ARG_WIDTH-1];
  assign w_scaled   = $signed({argument[ARG_WIDTH-1], argument}) >>> SHIFT;
  assign w_hsig     = w_scaled + C_HALF;

  // Select the function; ends of the linear region are inclusive (pass=1).
  always_comb begin
    act  = '0;
    pass = 1'b1;
    case (mode)
      RELU: begin
        if (w_negative) begin
          act  = '0;
          pass = 1'b0;
        end else if (w_scaled > C_ACT_MAX) begin
          act  = '1;
          pass = 1'b0;
        end else begin
          act  = w_scaled[ACT_WIDTH-1:0];
          pass = 1'b1;
        end
      end
      HSIG: begin
        if (w_hsig[ARG_WIDTH]) begin
          act  = '0;
          pass = 1'b0;
        end else if (w_hsig > C_ACT_MAX) begin
          act  = '1;
          pass = 1'b0;
        end else begin
          act  = w_hsig[ACT_WIDTH-1:0];
          pass = 1'b1;
        end
      end
      default: begin
        // Step: straight-through estimator, gradient always passes.
        act  = w_negative ? '0 : '1;
        pass = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/activation_unit.sv
`default_nettype none
// ============================================================================
// Module   : activation_unit
// Brief    : Single-transaction activation stage with optional training
//            phase returning a gradient masked by the derivative region.
// Revision : 1.0 - initial release
// ============================================================================
module activation_unit
  import activation_pkg::*;
#(
  parameter int ARG_WIDTH = 16,
  parameter int ACT_WIDTH = 8,
  parameter int FBK_WIDTH = 16,
  parameter int SHIFT     = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               train,
  input  logic [1:0]         mode,
  activation_unit_if.slave   bus
);

  state_t               r_state;
  state_t               w_next_state;
  mode_t                r_mode;
  logic                 r_train;
  logic                 r_pass;
  logic [ACT_WIDTH-1:0] r_act_data;
  logic [FBK_WIDTH-1:0] r_delta_data;

  mode_t                w_mode;
  logic [ACT_WIDTH-1:0] w_act;
  logic                 w_pass;
  logic                 w_mask;
  logic                 w_arg_hs;
  logic                 w_act_hs;
  logic                 w_fbk_hs;
  logic                 w_del_hs;

  assign w_mode   = mode_t'(mode);
  assign w_arg_hs = (r_state == ARG) && bus.argument_valid;
  assign w_act_hs = (r_state == ACT) && bus.activation_ready;
  assign w_fbk_hs = (r_state == FBK) && bus.feedback_valid;
  assign w_del_hs = (r_state == DEL) && bus.delta_ready;

  // Step-like modes always let the gradient through regardless of range.
  assign w_mask = r_pass || (r_mode == STEP) || (r_mode == RSVD);

  activation_function #(
    .ARG_WIDTH (ARG_WIDTH),
    .ACT_WIDTH (ACT_WIDTH),
    .SHIFT     (SHIFT)
  ) u_activation_function (
    .mode     (w_mode),
    .argument (bus.argument_data),
    .act      (w_act),
    .pass     (w_pass)
  );

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ARG;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: advance one phase per handshake, skip training if not latched.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARG: if (w_arg_hs) w_next_state = ACT;
      ACT: if (w_act_hs) w_next_state = r_train ? FBK : ARG;
      FBK: if (w_fbk_hs) w_next_state = DEL;
      DEL: if (w_del_hs) w_next_state = ARG;
      default: w_next_state = ARG;
    endcase
  end

  // Outputs: all handshake flags are decoded from the registered state.
  always_comb begin
    bus.argument_ready   = (r_state == ARG);
    bus.activation_valid = (r_state == ACT);
    bus.feedback_ready   = (r_state == FBK);
    bus.delta_valid      = (r_state == DEL);
    bus.activation_data  = r_act_data;
    bus.delta_data       = r_delta_data;
  end

  // Capture the transaction context at the argument and feedback handshakes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mode       <= STEP;
      r_train      <= 1'b0;
      r_pass       <= 1'b0;
      r_act_data   <= '0;
      r_delta_data <= '0;
    end else begin
      if (w_arg_hs) begin
        r_mode     <= w_mode;
        r_train    <= train;
        r_pass     <= w_pass;
        r_act_data <= w_act;
      end
      if (w_fbk_hs) begin
        r_delta_data <= w_mask ? bus.feedback_data : '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_activation_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_activation_unit
// Brief    : Scoreboard bench for activation_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_activation_unit;
  import activation_pkg::*;

  logic       clock;
  logic       reset_n;
  logic       train;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;

  logic [7:0]  act_q[$];
  logic [15:0] del_q[$];

  activation_unit_if #(.ARG_WIDTH(16), .ACT_WIDTH(8), .FBK_WIDTH(16)) bus ();

  activation_unit #(
    .ARG_WIDTH (16),
    .ACT_WIDTH (8),
    .FBK_WIDTH (16),
    .SHIFT     (4)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .train   (train),
    .mode    (mode),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: returns {pass, act}.
  function automatic logic [8:0] model(input logic [1:0] m, input logic [15:0] a);
    int ai;
    int s;
    int t;
    logic [7:0] act;
    logic       pass;
    ai = int'($signed(a));
    s  = ai >>> 4;
    t  = s + 128;
    case (m)
      2'd1: begin
        act  = (ai < 0) ? 8'd0 : (s > 255) ? 8'd255 : 8'(s);
        pass = (ai >= 0) && (s <= 255);
      end
      2'd2: begin
        act  = (t < 0) ? 8'd0 : (t > 255) ? 8'd255 : 8'(t);
        pass = (t >= 0) && (t <= 255);
      end
      default: begin
        act  = (ai >= 0) ? 8'hFF : 8'h00;
        pass = 1'b1;
      end
    endcase
    return {pass, act};
  endfunction

  // Output monitor: pops the scoreboard on every handshake.
  always @(negedge clock) begin
    if (bus.activation_valid && bus.activation_ready) begin
      if (act_q.size() == 0) check("act_unexpected", 32'd1, 32'd0);
      else check("act_data", 32'(bus.activation_data), 32'(act_q.pop_front()));
    end
    if (bus.delta_valid && bus.delta_ready) begin
      if (del_q.size() == 0) check("del_unexpected", 32'd1, 32'd0);
      else check("delta_data", 32'(bus.delta_data), 32'(del_q.pop_front()));
    end
  end

  // One full transaction; entered and left 1 time unit after a rising edge.
  task automatic txn(input logic [1:0] m, input logic tr, input logic [15:0] a,
                     input logic [15:0] fb, input int act_stall, input int del_stall,
                     input bit toggle, input bit rst_in_del);
    logic [8:0] r;
    int n;
    r = model(m, a);
    act_q.push_back(r[7:0]);
    if (tr) del_q.push_back(r[8] ? fb : 16'h0000);

    // Argument phase
    bus.argument_valid = 1'b1;
    bus.argument_data  = a;
    mode  = m;
    train = tr;
    n = 0;
    @(negedge clock);
    while (!bus.argument_ready && n < 20) begin @(negedge clock); n++; end
    if (n == 20) check("arg_timeout", 32'd0, 32'd1);
    @(posedge clock); #1;
    bus.argument_valid = 1'b0;
    bus.argument_data  = 16'hDEAD;
    if (toggle) begin
      mode  = 2'd0;
      train = ~tr;
    end

    // Activation phase with optional backpressure
    for (int i = 0; i < act_stall; i++) begin
      @(negedge clock);
      check("act_hold_valid", 32'(bus.activation_valid), 32'd1);
      check("act_hold_data", 32'(bus.activation_data), 32'(r[7:0]));
      @(posedge clock); #1;
    end
    bus.activation_ready = 1'b1;
    n = 0;
    @(negedge clock);
    while (!bus.activation_valid && n < 20) begin @(negedge clock); n++; end
    if (n == 20) check("act_timeout", 32'd0, 32'd1);
    @(posedge clock); #1;
    bus.activation_ready = 1'b0;
    check("act_clear", 32'(bus.activation_valid), 32'd0);
    check("fbk_ready", 32'(bus.feedback_ready), 32'(tr));
    if (!tr) begin
      check("arg_ready_after", 32'(bus.argument_ready), 32'd1);
      return;
    end

    // Feedback phase
    bus.feedback_valid = 1'b1;
    bus.feedback_data  = fb;
    @(posedge clock); #1;
    bus.feedback_valid = 1'b0;
    bus.feedback_data  = 16'h0BAD;

    // Delta phase with optional backpressure or reset
    for (int i = 0; i < del_stall; i++) begin
      @(negedge clock);
      check("del_hold_valid", 32'(bus.delta_valid), 32'd1);
      if (del_q.size() != 0) check("del_hold_data", 32'(bus.delta_data), 32'(del_q[0]));
      @(posedge clock); #1;
    end
    if (rst_in_del) begin
      @(negedge clock); #1;
      reset_n = 1'b0;
      #1;
      check("rst_delta_valid", 32'(bus.delta_valid), 32'd0);
      check("rst_delta_data", 32'(bus.delta_data), 32'd0);
      check("rst_act_valid", 32'(bus.activation_valid), 32'd0);
      #1;
      reset_n = 1'b1;
      del_q.delete();
      @(posedge clock); #1;
      check("rst_arg_ready", 32'(bus.argument_ready), 32'd1);
      check("rst_no_delta", 32'(bus.delta_valid), 32'd0);
      return;
    end
    bus.delta_ready = 1'b1;
    n = 0;
    @(negedge clock);
    while (!bus.delta_valid && n < 20) begin @(negedge clock); n++; end
    if (n == 20) check("del_timeout", 32'd0, 32'd1);
    @(posedge clock); #1;
    bus.delta_ready = 1'b0;
    check("del_clear", 32'(bus.delta_valid), 32'd0);
    check("arg_ready_after_del", 32'(bus.argument_ready), 32'd1);
  endtask

  initial begin
    reset_n              = 1'b0;
    train                = 1'b0;
    mode                 = 2'd0;
    bus.argument_valid   = 1'b0;
    bus.argument_data    = '0;
    bus.activation_ready = 1'b0;
    bus.feedback_valid   = 1'b0;
    bus.feedback_data    = '0;
    bus.delta_ready      = 1'b0;

    #12;
    check("rst_act_valid0", 32'(bus.activation_valid), 32'd0);
    check("rst_del_valid0", 32'(bus.delta_valid), 32'd0);
    check("rst_act_data0", 32'(bus.activation_data), 32'd0);
    check("rst_del_data0", 32'(bus.delta_data), 32'd0);
    check("rst_fbk_ready0", 32'(bus.feedback_ready), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("arg_ready0", 32'(bus.argument_ready), 32'd1);

    txn(2'd0, 1'b0, 16'h0000, 16'h0000, 0, 0, 1'b0, 1'b0);
    txn(2'd0, 1'b0, 16'hFFFF, 16'h0000, 0, 0, 1'b0, 1'b0);
    txn(2'd1, 1'b1, 16'h0100, 16'h1234, 0, 0, 1'b0, 1'b0);
    txn(2'd1, 1'b1, 16'h1000, 16'h1234, 0, 0, 1'b0, 1'b0);
    txn(2'd2, 1'b1, 16'h0100, 16'h5A5A, 0, 0, 1'b0, 1'b0);
    txn(2'd2, 1'b1, 16'hF700, 16'h4321, 0, 0, 1'b0, 1'b0);
    txn(2'd2, 1'b1, 16'h07F0, 16'h7777, 0, 0, 1'b0, 1'b0);
    txn(2'd1, 1'b1, 16'h0350, 16'hBEEF, 5, 3, 1'b0, 1'b0);
    txn(2'd1, 1'b1, 16'h0200, 16'h0F0F, 0, 0, 1'b1, 1'b0);
    txn(2'd2, 1'b1, 16'h0000, 16'h1111, 0, 2, 1'b0, 1'b1);
    txn(2'd0, 1'b0, 16'h0001, 16'h0000, 0, 0, 1'b0, 1'b0);
    txn(2'd3, 1'b1, 16'h8000, 16'hABCD, 0, 0, 1'b0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      txn(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 16'($urandom),
          16'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
          1'b0, 1'b0);
    end

    repeat (3) @(posedge clock);
    check("act_q_drained", act_q.size(), 32'd0);
    check("del_q_drained", del_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
